// File: rtl/aes_round_sequencer_if.sv
// Handshake and round-control bundle between the AES round sequencer and its
// upstream staging register, round datapath and key-schedule store.
interface aes_round_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       decrypt;
   logic       mode_dec;
   logic       initial_add;
   logic       round_en;
   logic       final_round;
   logic [3:0] round_idx;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   modport master (
      output in_valid, decrypt, out_ready,
      input  in_ready, mode_dec, initial_add, round_en, final_round, round_idx,
             out_valid, busy
   );

   modport slave (
      input  in_valid, decrypt, out_ready,
      output in_ready, mode_dec, initial_add, round_en, final_round, round_idx,
             out_valid, busy
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM sequencing the initial AddRoundKey and NUM_ROUNDS cipher rounds for
// one block, with ascending (enc) or descending (dec) round-key indices.
module aes_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input logic                   clock,
   input logic                   reset,
   aes_round_sequencer_if.slave  bus_io
);

   typedef enum logic [1:0] {StIdle, StInit, StRound, StDone} state_e;

   localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       mode_q, mode_d;
   logic       in_ready;
   logic       accept;
   logic       final_round;

   assign in_ready = (state_q == StIdle) | ((state_q == StDone) & bus_io.out_ready);
   assign accept   = bus_io.in_valid & in_ready;

   assign final_round = (state_q == StRound) &
                        ((~mode_q & (idx_q == LastIdx)) | (mode_q & (idx_q == 4'd0)));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      unique case (state_q)
         StIdle, StDone: begin
            // DONE with out_ready behaves like IDLE, giving back-to-back accept.
            if (accept) begin
               mode_d  = bus_io.decrypt;
               idx_d   = bus_io.decrypt ? LastIdx : 4'd0;
               state_d = StInit;
            end else if (state_q == StDone && bus_io.out_ready) begin
               state_d = StIdle;
            end
         end
         StInit: begin
            idx_d   = mode_q ? (LastIdx - 4'd1) : 4'd1;
            state_d = StRound;
         end
         StRound: begin
            if (final_round) begin
               state_d = StDone;
            end else begin
               idx_d = mode_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
      end
   end

   assign bus_io.in_ready    = in_ready;
   assign bus_io.mode_dec    = mode_q;
   assign bus_io.initial_add = (state_q == StInit);
   assign bus_io.round_en    = (state_q == StRound);
   assign bus_io.final_round = final_round;
   assign bus_io.round_idx   = idx_q;
   assign bus_io.out_valid   = (state_q == StDone);
   assign bus_io.busy        = (state_q == StInit) | (state_q == StRound);

endmodule
